mem_port_arbiter: RTL and testbench

- Shares the single-port program/data memory among three requesters: the external program loader, instruction fetch (phase P1) and load/store data access (phases P4/P5).
- Runs one access at a time through a three-state FSM.
- Each granted access drives the memory for exactly one cycle and returns a registered read-data word plus a one-cycle valid/acknowledge pulse to its owner.
- Replaces the direct phase-decoded memory address muxing in front of memory.

---
 rtl/mem_port_arbiter.sv | 181 ++++++++++++++++++
 tb/tb_mem_port_arbiter.sv | 337 +++++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/mem_port_arbiter.sv
// Single-port memory arbiter for loader, instruction fetch and data access.
// Define ARB_ROUND_ROBIN_EN to alternate between data and fetch on contention.
module mem_port_arbiter #(
    parameter int ADDR_W = 16,
    parameter int DATA_W = 16
) (
    input  logic              clock,
    input  logic              resetN,
    input  logic              loadReq,
    input  logic              loadWe,
    input  logic [ADDR_W-1:0] loadAddr,
    input  logic [DATA_W-1:0] loadWdata,
    output logic              loadGnt,
    output logic              loadValid,
    input  logic              fetchReq,
    input  logic [ADDR_W-1:0] fetchAddr,
    output logic              fetchGnt,
    output logic              fetchValid,
    input  logic              dataReq,
    input  logic              dataWe,
    input  logic [ADDR_W-1:0] dataAddr,
    input  logic [DATA_W-1:0] dataWdata,
    output logic              dataGnt,
    output logic              dataValid,
    output logic [DATA_W-1:0] rdata,
    output logic              memEn,
    output logic              memWe,
    output logic [ADDR_W-1:0] memAddr,
    output logic [DATA_W-1:0] memWdata,
    input  logic [DATA_W-1:0] memRdata,
    output logic [1:0]        owner
);

    typedef enum logic [1:0] {S_IDLE, S_ACCESS, S_RESP} state_t;

    localparam logic [1:0] OWN_NONE  = 2'd0;
    localparam logic [1:0] OWN_LOAD  = 2'd1;
    localparam logic [1:0] OWN_FETCH = 2'd2;
    localparam logic [1:0] OWN_DATA  = 2'd3;

    state_t            r_state, w_stateNext;
    logic [1:0]        r_owner;
    logic [2:0]        r_gnt;     // {data, fetch, loader}
    logic [2:0]        r_valid;
    logic              r_memEn, r_memWe, r_opWe;
    logic [ADDR_W-1:0] r_memAddr;
    logic [DATA_W-1:0] r_memWdata;
    logic [DATA_W-1:0] r_rdata;

    logic [1:0]        w_winner;
    logic              w_arb;
    logic              w_selWe;
    logic [ADDR_W-1:0] w_selAddr;
    logic [DATA_W-1:0] w_selWdata;

    function automatic logic [2:0] one_hot(input logic [1:0] own);
        case (own)
            OWN_LOAD:  one_hot = 3'b001;
            OWN_FETCH: one_hot = 3'b010;
            OWN_DATA:  one_hot = 3'b100;
            default:   one_hot = 3'b000;
        endcase
    endfunction

`ifdef ARB_ROUND_ROBIN_EN
    logic r_lastData;  // 1: data was the more recent of data/fetch grants

    always_ff @(posedge clock) begin
        if (!resetN)
            r_lastData <= 1'b1;
        else if (w_arb && w_winner == OWN_FETCH)
            r_lastData <= 1'b0;
        else if (w_arb && w_winner == OWN_DATA)
            r_lastData <= 1'b1;
    end
`endif

    always_comb begin
        w_winner = OWN_NONE;
        if (loadReq)
            w_winner = OWN_LOAD;
        else if (dataReq && fetchReq)
`ifdef ARB_ROUND_ROBIN_EN
            w_winner = r_lastData ? OWN_FETCH : OWN_DATA;
`else
            w_winner = OWN_DATA;
`endif
        else if (dataReq)
            w_winner = OWN_DATA;
        else if (fetchReq)
            w_winner = OWN_FETCH;
    end

    // Requests are only looked at outside ACCESS.
    assign w_arb = (r_state != S_ACCESS) && (w_winner != OWN_NONE);

    always_comb begin
        w_selWe    = 1'b0;
        w_selAddr  = fetchAddr;
        w_selWdata = '0;
        case (w_winner)
            OWN_LOAD: begin
                w_selWe    = loadWe;
                w_selAddr  = loadAddr;
                w_selWdata = loadWdata;
            end
            OWN_DATA: begin
                w_selWe    = dataWe;
                w_selAddr  = dataAddr;
                w_selWdata = dataWdata;
            end
            default: ;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetN)
            r_state <= S_IDLE;
        else
            r_state <= w_stateNext;
    end

    always_comb begin
        w_stateNext = S_IDLE;
        case (r_state)
            S_IDLE:   w_stateNext = w_arb ? S_ACCESS : S_IDLE;
            S_ACCESS: w_stateNext = S_RESP;
            S_RESP:   w_stateNext = w_arb ? S_ACCESS : S_IDLE;
            default:  w_stateNext = S_IDLE;
        endcase
    end

    always_ff @(posedge clock) begin
        if (!resetN) begin
            r_owner    <= OWN_NONE;
            r_gnt      <= '0;
            r_valid    <= '0;
            r_memEn    <= 1'b0;
            r_memWe    <= 1'b0;
            r_opWe     <= 1'b0;
            r_memAddr  <= '0;
            r_memWdata <= '0;
            r_rdata    <= '0;
        end else begin
            r_gnt   <= '0;
            r_valid <= '0;
            r_memEn <= 1'b0;
            r_memWe <= 1'b0;
            if (r_state == S_RESP) begin
                if (!r_opWe)
                    r_rdata <= memRdata;
                r_valid <= one_hot(r_owner);
                if (!w_arb)
                    r_owner <= OWN_NONE;
            end
            if (w_arb) begin
                r_owner    <= w_winner;
                r_gnt      <= one_hot(w_winner);
                r_memEn    <= 1'b1;
                r_memWe    <= w_selWe;
                r_opWe     <= w_selWe;
                r_memAddr  <= w_selAddr;
                r_memWdata <= w_selWdata;
            end
        end
    end

    assign loadGnt    = r_gnt[0];
    assign fetchGnt   = r_gnt[1];
    assign dataGnt    = r_gnt[2];
    assign loadValid  = r_valid[0];
    assign fetchValid = r_valid[1];
    assign dataValid  = r_valid[2];
    assign rdata      = r_rdata;
    assign memEn      = r_memEn;
    assign memWe      = r_memWe;
    assign memAddr    = r_memAddr;
    assign memWdata   = r_memWdata;
    assign owner      = r_owner;

endmodule

// File: tb/tb_mem_port_arbiter.sv
// Directed bench for mem_port_arbiter with a behavioural synchronous memory.
module tb_mem_port_arbiter;

    logic        clock = 1'b0;
    logic        resetN;
    logic        loadReq, loadWe;
    logic [15:0] loadAddr, loadWdata;
    logic        loadGnt, loadValid;
    logic        fetchReq;
    logic [15:0] fetchAddr;
    logic        fetchGnt, fetchValid;
    logic        dataReq, dataWe;
    logic [15:0] dataAddr, dataWdata;
    logic        dataGnt, dataValid;
    logic [15:0] rdata;
    logic        memEn, memWe;
    logic [15:0] memAddr, memWdata;
    logic [15:0] memRdata;
    logic [1:0]  owner;

    int total = 0;
    int bad   = 0;
    int weCnt = 0;

    logic [15:0] mem [0:65535];

    mem_port_arbiter #(.ADDR_W(16), .DATA_W(16)) dut (
        .clock(clock), .resetN(resetN),
        .loadReq(loadReq), .loadWe(loadWe), .loadAddr(loadAddr), .loadWdata(loadWdata),
        .loadGnt(loadGnt), .loadValid(loadValid),
        .fetchReq(fetchReq), .fetchAddr(fetchAddr),
        .fetchGnt(fetchGnt), .fetchValid(fetchValid),
        .dataReq(dataReq), .dataWe(dataWe), .dataAddr(dataAddr), .dataWdata(dataWdata),
        .dataGnt(dataGnt), .dataValid(dataValid),
        .rdata(rdata),
        .memEn(memEn), .memWe(memWe), .memAddr(memAddr), .memWdata(memWdata),
        .memRdata(memRdata),
        .owner(owner)
    );

    always #5 clock = ~clock;

    // Read-first synchronous memory.
    always @(posedge clock) begin
        if (memEn) begin
            if (memWe)
                mem[memAddr] <= memWdata;
            memRdata <= mem[memAddr];
        end
    end

    always @(posedge clock)
        if (memEn && memWe)
            weCnt = weCnt + 1;

    task automatic tick;
        @(posedge clock);
        #1;
    endtask

    task automatic drop_all;
        loadReq = 1'b0; fetchReq = 1'b0; dataReq = 1'b0;
    endtask

    task automatic test_reset;
        resetN = 1'b0;
        loadReq = 1'b1; loadWe = 1'b0; loadAddr = 16'h0000; loadWdata = 16'h5555;
        fetchReq = 1'b1; fetchAddr = 16'h0000;
        dataReq = 1'b1; dataWe = 1'b1; dataAddr = 16'h0001; dataWdata = 16'hAAAA;
        for (int i = 0; i < 3; i++) begin
            tick;
            total++;
            if ({loadGnt, loadValid, fetchGnt, fetchValid, dataGnt, dataValid, memEn, memWe} !== 8'h00) begin
                bad++;
                $display("FAIL reset_strobes cyc%0d: got %b want 00000000", i,
                         {loadGnt, loadValid, fetchGnt, fetchValid, dataGnt, dataValid, memEn, memWe});
            end
            total++;
            if ({owner, rdata, memAddr, memWdata} !== 50'h0) begin
                bad++;
                $display("FAIL reset_regs cyc%0d: owner=%0d rdata=%h memAddr=%h memWdata=%h want all 0",
                         i, owner, rdata, memAddr, memWdata);
            end
        end
        resetN = 1'b1;
        tick;
        total++;
        if (loadGnt !== 1'b1 || owner !== 2'd1 || fetchGnt !== 1'b0 || dataGnt !== 1'b0) begin
            bad++;
            $display("FAIL reset_first_grant: loadGnt=%b fetchGnt=%b dataGnt=%b owner=%0d want 1 0 0 1",
                     loadGnt, fetchGnt, dataGnt, owner);
        end
        drop_all;
        tick;
        tick;
        total++;
        if (loadValid !== 1'b1 || owner !== 2'd0) begin
            bad++;
            $display("FAIL reset_first_valid: loadValid=%b owner=%0d want 1 0", loadValid, owner);
        end
        tick;
    endtask

    task automatic test_single_read;
        fetchReq = 1'b1; fetchAddr = 16'h0010;
        tick;
        total++;
        if (fetchGnt !== 1'b1 || owner !== 2'd2 || memEn !== 1'b1 || memWe !== 1'b0 || memAddr !== 16'h0010) begin
            bad++;
            $display("FAIL read_grant: gnt=%b owner=%0d memEn=%b memWe=%b memAddr=%h want 1 2 1 0 0010",
                     fetchGnt, owner, memEn, memWe, memAddr);
        end
        fetchReq = 1'b0;
        tick;
        total++;
        if (fetchGnt !== 1'b0 || memEn !== 1'b0 || fetchValid !== 1'b0) begin
            bad++;
            $display("FAIL read_resp_cycle: gnt=%b memEn=%b valid=%b want 0 0 0", fetchGnt, memEn, fetchValid);
        end
        tick;
        total++;
        if (fetchValid !== 1'b1 || rdata !== 16'hC3A5 || owner !== 2'd0) begin
            bad++;
            $display("FAIL read_valid: valid=%b rdata=%h owner=%0d want 1 c3a5 0", fetchValid, rdata, owner);
        end
        tick;
        total++;
        if (fetchValid !== 1'b0) begin
            bad++;
            $display("FAIL read_valid_pulse: valid=%b want 0", fetchValid);
        end
    endtask

    task automatic test_write_read;
        int cnt0;
        cnt0 = weCnt;
        dataReq = 1'b1; dataWe = 1'b1; dataAddr = 16'h0020; dataWdata = 16'h1234;
        tick;
        total++;
        if (dataGnt !== 1'b1 || memWe !== 1'b1 || memAddr !== 16'h0020 || memWdata !== 16'h1234) begin
            bad++;
            $display("FAIL write_grant: gnt=%b memWe=%b memAddr=%h memWdata=%h want 1 1 0020 1234",
                     dataGnt, memWe, memAddr, memWdata);
        end
        dataReq = 1'b0;
        tick;
        total++;
        if (memWe !== 1'b0 || memEn !== 1'b0) begin
            bad++;
            $display("FAIL write_strobe_len: memEn=%b memWe=%b want 0 0", memEn, memWe);
        end
        tick;
        total++;
        if (dataValid !== 1'b1 || rdata !== 16'hC3A5 || fetchValid !== 1'b0) begin
            bad++;
            $display("FAIL write_valid: dataValid=%b rdata=%h fetchValid=%b want 1 c3a5 0",
                     dataValid, rdata, fetchValid);
        end
        total++;
        if (weCnt - cnt0 != 1 || mem[16'h0020] !== 16'h1234) begin
            bad++;
            $display("FAIL write_effect: pulses=%0d mem=%h want 1 1234", weCnt - cnt0, mem[16'h0020]);
        end
        tick;
        fetchReq = 1'b1; fetchAddr = 16'h0020;
        tick;
        fetchReq = 1'b0;
        tick;
        tick;
        total++;
        if (fetchValid !== 1'b1 || rdata !== 16'h1234) begin
            bad++;
            $display("FAIL readback: valid=%b rdata=%h want 1 1234", fetchValid, rdata);
        end
        tick;
    endtask

    task automatic test_contention;
        int order [3];
        int gcyc  [3];
        int n;
        int exp_order [3];
`ifdef ARB_ROUND_ROBIN_EN
        exp_order = '{1, 2, 3};
`else
        exp_order = '{1, 3, 2};
`endif
        resetN = 1'b0;
        tick;
        resetN = 1'b1;
        n = 0;
        loadReq = 1'b1; loadWe = 1'b0; loadAddr = 16'h0010;
        fetchReq = 1'b1; fetchAddr = 16'h0010;
        dataReq = 1'b1; dataWe = 1'b0; dataAddr = 16'h0020;
        for (int cyc = 0; cyc < 20 && n < 3; cyc++) begin
            tick;
            if (int'(loadGnt) + int'(fetchGnt) + int'(dataGnt) > 1 ||
                int'(loadValid) + int'(fetchValid) + int'(dataValid) > 1) begin
                total++; bad++;
                $display("FAIL contention_onehot cyc%0d: gnt=%b%b%b valid=%b%b%b",
                         cyc, loadGnt, fetchGnt, dataGnt, loadValid, fetchValid, dataValid);
            end
            if (loadGnt)  begin order[n] = 1; gcyc[n] = cyc; n++; loadReq  = 1'b0; end
            else if (fetchGnt) begin order[n] = 2; gcyc[n] = cyc; n++; fetchReq = 1'b0; end
            else if (dataGnt)  begin order[n] = 3; gcyc[n] = cyc; n++; dataReq  = 1'b0; end
        end
        total++;
        if (n != 3) begin
            bad++;
            $display("FAIL contention_timeout: grants=%0d want 3", n);
        end else begin
            for (int i = 0; i < 3; i++) begin
                total++;
                if (order[i] != exp_order[i]) begin
                    bad++;
                    $display("FAIL contention_order[%0d]: got owner %0d want %0d", i, order[i], exp_order[i]);
                end
            end
            total++;
            if (gcyc[1] - gcyc[0] != 2 || gcyc[2] - gcyc[1] != 2) begin
                bad++;
                $display("FAIL contention_spacing: gaps %0d %0d want 2 2", gcyc[1] - gcyc[0], gcyc[2] - gcyc[1]);
            end
        end
        drop_all;
        repeat (3) tick;
    endtask

    // Fetch and data both held; alternation with round-robin, data always wins otherwise.
    task automatic test_fetch_data_arbitration;
        int n;
        int last;
        int exp;
        resetN = 1'b0;
        tick;
        resetN = 1'b1;
        n = 0;
        last = -10;
        fetchReq = 1'b1; fetchAddr = 16'h0010;
        dataReq = 1'b1; dataWe = 1'b0; dataAddr = 16'h0020;
        for (int cyc = 0; cyc < 40 && n < 8; cyc++) begin
            tick;
            if (fetchValid && dataValid) begin
                total++; bad++;
                $display("FAIL arb_valid_overlap cyc%0d: fetchValid=1 dataValid=1", cyc);
            end
            if (fetchGnt || dataGnt) begin
`ifdef ARB_ROUND_ROBIN_EN
                exp = (n % 2 == 0) ? 2 : 3;
`else
                exp = 3;
`endif
                total++;
                if (int'(owner) != exp || (fetchGnt && dataGnt)) begin
                    bad++;
                    $display("FAIL arb_grant[%0d]: owner=%0d fetchGnt=%b dataGnt=%b want owner %0d",
                             n, owner, fetchGnt, dataGnt, exp);
                end
                if (n > 0) begin
                    total++;
                    if (cyc - last != 2) begin
                        bad++;
                        $display("FAIL arb_spacing[%0d]: gap=%0d want 2", n, cyc - last);
                    end
                end
                last = cyc;
                n++;
            end
        end
        total++;
        if (n != 8) begin
            bad++;
            $display("FAIL arb_timeout: grants=%0d want 8", n);
        end
        drop_all;
        repeat (3) tick;
    endtask

    task automatic test_reset_mid_access;
        int cnt0;
        cnt0 = weCnt;
        dataReq = 1'b1; dataWe = 1'b1; dataAddr = 16'h0030; dataWdata = 16'hBEEF;
        tick;
        total++;
        if (memWe !== 1'b1 || dataGnt !== 1'b1) begin
            bad++;
            $display("FAIL abort_setup: memWe=%b dataGnt=%b want 1 1", memWe, dataGnt);
        end
        dataReq = 1'b0;
        resetN = 1'b0;
        tick;
        total++;
        if (memWe !== 1'b0 || memEn !== 1'b0 || owner !== 2'd0 || rdata !== 16'h0000) begin
            bad++;
            $display("FAIL abort_reset_edge: memWe=%b memEn=%b owner=%0d rdata=%h want 0 0 0 0000",
                     memWe, memEn, owner, rdata);
        end
        resetN = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick;
            total++;
            if (dataValid !== 1'b0 || memWe !== 1'b0 || memEn !== 1'b0) begin
                bad++;
                $display("FAIL abort_quiet cyc%0d: dataValid=%b memWe=%b memEn=%b want 0 0 0",
                         i, dataValid, memWe, memEn);
            end
        end
        total++;
        if (weCnt - cnt0 != 1) begin
            bad++;
            $display("FAIL abort_write_count: pulses=%0d want 1", weCnt - cnt0);
        end
    endtask

    initial begin
        for (int a = 0; a < 65536; a++)
            mem[a] = 16'h0000;
        mem[16'h0010] = 16'hC3A5;
        memRdata = 16'h0000;
        resetN = 1'b0;
        drop_all;
        loadWe = 1'b0; loadAddr = '0; loadWdata = '0;
        fetchAddr = '0;
        dataWe = 1'b0; dataAddr = '0; dataWdata = '0;

        test_reset;
        test_single_read;
        test_write_read;
        test_contention;
        test_fetch_data_arbitration;
        test_reset_mid_access;

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
